// File: rtl/top_ddr_sfp_status_poller.sv
// -----------------------------------------------------------------------------
// top_ddr_sfp_status_poller
//
// Purpose:
//   Avalon-MM read master that periodically polls a small status PIO slave
//   (offset 0). Each sample goes through a consecutive-match stability filter.
//   Accepted values are published on status_out. A change between accepted
//   values is reported by a one-cycle pulse, a saturating counter and a sticky
//   interrupt.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            1 = polling active
//   avm_address       Avalon address (constant 0)
//   avm_read          Avalon read request, held through waitrequest
//   avm_waitrequest   slave stall
//   avm_readdata      slave data; only [DATA_W-1:0] is used
//   status_out        last accepted (stable) status
//   status_valid      set once the first value has been accepted
//   change_pulse      one-cycle strobe on an accepted change
//   change_count      number of accepted changes, saturating
//   irq / irq_ack     sticky change interrupt and its clear
// -----------------------------------------------------------------------------
module top_ddr_sfp_status_poller #(
    parameter int DATA_W       = 3,
    parameter int POLL_DIV     = 1000,
    parameter int READ_LATENCY = 1,
    parameter int STABLE_CNT   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] status_out,
    output logic              status_valid,
    output logic              change_pulse,
    output logic [15:0]       change_count,
    output logic              irq,
    input  logic              irq_ack
);

    localparam int TW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int MW = $clog2(STABLE_CNT + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
    localparam logic [LW-1:0] LAT_LAST   = LW'(READ_LATENCY - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(STABLE_CNT);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic [DATA_W-1:0]  candidate_q, candidate_d;
    logic [MW-1:0]      match_q, match_d;
    logic [DATA_W-1:0]  status_q, status_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic [15:0]        change_count_q, change_count_d;
    logic               irq_q, irq_d;
    logic               avm_read_q, avm_read_d;

    // Next-state and datapath update for the poll FSM
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        lat_d          = lat_q;
        sample_d       = sample_q;
        candidate_d    = candidate_q;
        match_d        = match_q;
        status_d       = status_q;
        valid_d        = valid_q;
        pulse_d        = 1'b0;
        change_count_d = change_count_q;
        if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        state_d = S_READ;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            S_READ: begin
                // The request is never withdrawn once raised, even if enable drops.
                if (!avm_waitrequest) begin
                    lat_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_READ;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    sample_d = avm_readdata[DATA_W-1:0];
                    state_d  = S_EVAL;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                timer_d = '0;
                if (sample_q == candidate_q) begin
                    if (match_q < MATCH_MAX) begin
                        match_d = match_q + MW'(1);
                    end else begin
                        match_d = match_q;
                    end
                end else begin
                    candidate_d = sample_q;
                    match_d     = MATCH_ONE;
                end
                // Acceptance uses the freshly updated candidate/match count.
                if ((match_d >= MATCH_MAX) && (!valid_q || (candidate_d != status_q))) begin
                    status_d = candidate_d;
                    valid_d  = 1'b1;
                    if (valid_q) begin
                        pulse_d = 1'b1;
                        irq_d   = 1'b1;   // a set beats a simultaneous ack
                        if (change_count_q != 16'hFFFF) begin
                            change_count_d = change_count_q + 16'd1;
                        end else begin
                            change_count_d = change_count_q;
                        end
                    end else begin
                        pulse_d = 1'b0;
                    end
                end else begin
                    status_d = status_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered request: high exactly while the FSM sits in READ.
        avm_read_d = (state_d == S_READ);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            lat_q          <= '0;
            sample_q       <= '0;
            candidate_q    <= '0;
            match_q        <= '0;
            status_q       <= '0;
            valid_q        <= 1'b0;
            pulse_q        <= 1'b0;
            change_count_q <= 16'd0;
            irq_q          <= 1'b0;
            avm_read_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            lat_q          <= lat_d;
            sample_q       <= sample_d;
            candidate_q    <= candidate_d;
            match_q        <= match_d;
            status_q       <= status_d;
            valid_q        <= valid_d;
            pulse_q        <= pulse_d;
            change_count_q <= change_count_d;
            irq_q          <= irq_d;
            avm_read_q     <= avm_read_d;
        end
    end

    assign avm_address  = 2'd0;
    assign avm_read     = avm_read_q;
    assign status_out   = status_q;
    assign status_valid = valid_q;
    assign change_pulse = pulse_q;
    assign change_count = change_count_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_top_ddr_sfp_status_poller.sv
// -----------------------------------------------------------------------------
// tb_top_ddr_sfp_status_poller
//
// Directed bench for the status poller (POLL_DIV=8, READ_LATENCY=1,
// STABLE_CNT=2). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_top_ddr_sfp_status_poller;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [2:0]  status_out;
    logic        status_valid;
    logic        change_pulse;
    logic [15:0] change_count;
    logic        irq;
    logic        irq_ack;

    logic [2:0]  in_status;
    int          cyc;
    int          pulse_cnt;
    int          read_cnt;
    int          total;
    int          bad;

    assign avm_readdata = {29'd0, in_status};

    top_ddr_sfp_status_poller #(
        .DATA_W       (3),
        .POLL_DIV     (8),
        .READ_LATENCY (1),
        .STABLE_CNT   (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .status_out      (status_out),
        .status_valid    (status_valid),
        .change_pulse    (change_pulse),
        .change_count    (change_count),
        .irq             (irq),
        .irq_ack         (irq_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and event monitors
    initial begin
        cyc       = 0;
        pulse_cnt = 0;
        read_cnt  = 0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (change_pulse) pulse_cnt <= pulse_cnt + 1;
        if (avm_read && !avm_waitrequest) read_cnt <= read_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge where avm_read is high (bounded).
    task automatic wait_read(output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (avm_read) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) chk("read_timeout", 32'd0, 32'd1);
    endtask

    // One complete un-stalled poll: read, wait, eval, result visible.
    task automatic poll(output int t);
        wait_read(t);
        repeat (3) @(negedge clk);
    endtask

    int e, t1, t2, rc0;
    logic [2:0] sat_vals [3];

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        enable = 1'b0;
        avm_waitrequest = 1'b0;
        in_status = 3'd0;
        irq_ack = 1'b0;
        sat_vals[0] = 3'd5;
        sat_vals[1] = 3'd2;
        sat_vals[2] = 3'd5;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_status", {29'd0, status_out}, 32'd0);
        chk("rst_valid", {31'd0, status_valid}, 32'd0);
        chk("rst_pulse", {31'd0, change_pulse}, 32'd0);
        chk("rst_count", {16'd0, change_count}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_addr", {30'd0, avm_address}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: steady 5, first acceptance after two polls
        @(negedge clk);
        in_status = 3'd5;
        enable = 1'b1;
        e = cyc;
        poll(t1);
        chk("t1_first_read_delay", t1 - e, 32'd8);
        chk("t1_valid_after_1", {31'd0, status_valid}, 32'd0);
        poll(t2);
        chk("t1_period", t2 - t1, 32'd11);
        chk("t1_status", {29'd0, status_out}, 32'd5);
        chk("t1_valid", {31'd0, status_valid}, 32'd1);
        chk("t1_pulse", {31'd0, change_pulse}, 32'd0);
        chk("t1_irq", {31'd0, irq}, 32'd0);
        chk("t1_count", {16'd0, change_count}, 32'd0);

        // 2: change to 2, accepted after two polls
        in_status = 3'd2;
        poll(t1);
        chk("t2_status_hold", {29'd0, status_out}, 32'd5);
        poll(t1);
        chk("t2_status", {29'd0, status_out}, 32'd2);
        chk("t2_pulse", {31'd0, change_pulse}, 32'd1);
        chk("t2_count", {16'd0, change_count}, 32'd1);
        chk("t2_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("t2_pulse_one_cycle", {31'd0, change_pulse}, 32'd0);
        chk("t2_pulse_cnt", pulse_cnt, 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("t2_irq_ack", {31'd0, irq}, 32'd0);

        // 3: single-sample glitch is filtered
        in_status = 3'd5;
        poll(t1);
        in_status = 3'd2;
        poll(t1);
        poll(t1);
        chk("t3_status", {29'd0, status_out}, 32'd2);
        chk("t3_count", {16'd0, change_count}, 32'd1);
        chk("t3_pulse_cnt", pulse_cnt, 32'd1);

        // 4: 5-cycle stall, data taken exactly one cycle after acceptance
        avm_waitrequest = 1'b1;
        in_status = 3'd5;
        wait_read(t1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_read", {31'd0, avm_read}, 32'd1);
            chk("t4_stall_addr", {30'd0, avm_address}, 32'd0);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        in_status = 3'd7;
        @(negedge clk);
        in_status = 3'd5;
        @(negedge clk);
        in_status = 3'd6;
        @(negedge clk);
        in_status = 3'd5;
        chk("t4_status_hold", {29'd0, status_out}, 32'd2);
        poll(t1);
        chk("t4_status", {29'd0, status_out}, 32'd5);
        chk("t4_count", {16'd0, change_count}, 32'd2);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;

        // 5: enable dropped during a stalled read
        avm_waitrequest = 1'b1;
        wait_read(t1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_read_held", {31'd0, avm_read}, 32'd1);
        in_status = 3'd2;
        rc0 = read_cnt;
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_read_done", read_cnt - rc0, 32'd1);
        repeat (40) @(negedge clk);
        chk("t5_no_reads", read_cnt - rc0, 32'd1);
        chk("t5_read_low", {31'd0, avm_read}, 32'd0);
        chk("t5_status_hold", {29'd0, status_out}, 32'd5);
        enable = 1'b1;
        e = cyc;
        wait_read(t1);
        chk("t5_reenable_delay", t1 - e, 32'd8);

        // 6b: ack coincident with a set; the set wins
        @(negedge clk);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("t6_irq_set_wins", {31'd0, irq}, 32'd1);
        chk("t6_status", {29'd0, status_out}, 32'd2);
        chk("t6_count", {16'd0, change_count}, 32'd3);
        chk("t6_pulse", {31'd0, change_pulse}, 32'd1);

        // 6a: counter saturation
        @(negedge clk);
        force dut.change_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.change_count_q;
        chk("t6_count_preload", {16'd0, change_count}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) begin
            in_status = sat_vals[k];
            poll(t1);
            poll(t1);
            chk("t6_sat_status", {29'd0, status_out}, {29'd0, sat_vals[k]});
            chk("t6_sat_count", {16'd0, change_count}, 32'h0000FFFF);
        end

        // 6c: reset mid-WAIT
        wait_read(t1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_status", {29'd0, status_out}, 32'd0);
        chk("t6_rst_valid", {31'd0, status_valid}, 32'd0);
        chk("t6_rst_count", {16'd0, change_count}, 32'd0);
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        chk("t6_rst_pulse", {31'd0, change_pulse}, 32'd0);
        chk("t6_rst_read", {31'd0, avm_read}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // avm_read drops asynchronously when reset hits a stalled read
        avm_waitrequest = 1'b1;
        wait_read(t1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_read_async", {31'd0, avm_read}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
